id_stage_pipelined: RTL

//  Parametrised instruction-decode stage sitting between fetch (IF) and execute (EX).

---
 rtl/musa_id_pkg.sv | 70 +++++++
 rtl/id_regfile.sv | 51 +++++
 rtl/id_stage_pipelined.sv | 135 +++++++++++++
 3 files changed

// File: rtl/musa_id_pkg.sv
// Shared decode definitions for the ID stage: opcodes, ALU op classes and the
// opcode -> control decode table.
package musa_id_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [4:0] LINK_REG = 5'd31;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_LUI  = 3'd4,
        ALU_FUNC = 3'd5,
        ALU_LINK = 3'd6
    } alu_op_t;

    typedef enum logic [1:0] {
        EXT_SIGN = 2'd0,
        EXT_ZERO = 2'd1,
        EXT_LUI  = 2'd2
    } ext_mode_t;

    typedef struct packed {
        logic      reg_write;
        logic      mem_read;
        logic      mem_write;
        logic      branch;
        logic      jump;
        logic      illegal;
        logic      uses_rs;
        logic      uses_rt;
        ext_mode_t ext_mode;
        alu_op_t   alu_op;
    } ctrl_t;

    function automatic ctrl_t decode(input logic [5:0] opcode);
        ctrl_t c;
        c          = '0;
        c.ext_mode = EXT_SIGN;
        c.alu_op   = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin c.reg_write = 1'b1; c.uses_rs = 1'b1; c.uses_rt = 1'b1; c.alu_op = ALU_FUNC; end
            OP_LW:    begin c.mem_read = 1'b1; c.reg_write = 1'b1; c.uses_rs = 1'b1; end
            OP_SW:    begin c.mem_write = 1'b1; c.uses_rs = 1'b1; c.uses_rt = 1'b1; end
            OP_BEQ,
            OP_BNE:   begin c.branch = 1'b1; c.uses_rs = 1'b1; c.uses_rt = 1'b1; c.alu_op = ALU_SUB; end
            OP_J:     c.jump = 1'b1;
            OP_JAL:   begin c.jump = 1'b1; c.reg_write = 1'b1; c.alu_op = ALU_LINK; end
            OP_ADDI:  begin c.reg_write = 1'b1; c.uses_rs = 1'b1; end
            OP_ANDI:  begin c.reg_write = 1'b1; c.uses_rs = 1'b1; c.ext_mode = EXT_ZERO; c.alu_op = ALU_AND; end
            OP_ORI:   begin c.reg_write = 1'b1; c.uses_rs = 1'b1; c.ext_mode = EXT_ZERO; c.alu_op = ALU_OR; end
            OP_LUI:   begin c.reg_write = 1'b1; c.ext_mode = EXT_LUI; c.alu_op = ALU_LUI; end
            default:  c.illegal = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/id_regfile.sv
// Register file with two bypassed read ports (write-back forwarded in the same
// cycle) and one unbypassed debug read port.
module id_regfile
    import musa_id_pkg::*;
#(
    parameter int NREGS    = 32,
    parameter int XLEN     = 32,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_we,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic [4:0]      rs_addr,
    output logic [XLEN-1:0] rs_data,
    input  logic [4:0]      rt_addr,
    output logic [XLEN-1:0] rt_data,
    input  logic [4:0]      dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    localparam int RA_W = $clog2(NREGS);

    logic [XLEN-1:0] regs [NREGS];
    logic            wr_ok;

    function automatic logic in_range(input logic [4:0] a);
        return int'(a) < NREGS;
    endfunction

    assign wr_ok = wb_we && in_range(wb_addr) && !(ZERO_REG && (wb_addr == 5'd0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wr_ok) begin
            regs[wb_addr[RA_W-1:0]] <= wb_data;
        end
    end

    function automatic logic [XLEN-1:0] raw_read(input logic [4:0] a);
        return in_range(a) ? regs[a[RA_W-1:0]] : '0;
    endfunction

    // Bypass only when the write would actually land, so ignored writes never leak.
    assign rs_data  = (wr_ok && wb_addr == rs_addr) ? wb_data : raw_read(rs_addr);
    assign rt_data  = (wr_ok && wb_addr == rt_addr) ? wb_data : raw_read(rt_addr);
    assign dbg_data = raw_read(dbg_addr);

endmodule

// File: rtl/id_stage_pipelined.sv
// Instruction decode stage: operand read, decode, immediate extension, jump
// target, load-use interlock and the ID/EX pipeline register.
module id_stage_pipelined
    import musa_id_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic            id_ready,
    input  logic            flush,
    input  logic            ex_ready,
    input  logic            wb_we,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs_data,
    output logic [XLEN-1:0] ex_rt_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [XLEN-1:0] ex_jump_tgt,
    output logic [4:0]      ex_rd,
    output logic [5:0]      ex_func,
    output logic [2:0]      ex_alu_op,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_branch,
    output logic            ex_jump,
    output logic            ex_illegal,
    input  logic [4:0]      dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    logic [5:0]      opcode;
    logic [4:0]      rs, rt, rd_sel;
    logic [15:0]     imm16;
    ctrl_t           dec;
    logic [XLEN-1:0] rs_val, rt_val, imm_val, jump_tgt;
    logic            advance, load_use;

    assign opcode = if_instr[31:26];
    assign rs     = if_instr[25:21];
    assign rt     = if_instr[20:16];
    assign imm16  = if_instr[15:0];
    assign dec    = decode(opcode);

    id_regfile #(
        .NREGS    (NREGS),
        .XLEN     (XLEN),
        .ZERO_REG (ZERO_REG)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .wb_we    (wb_we),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .rs_addr  (rs),
        .rs_data  (rs_val),
        .rt_addr  (rt),
        .rt_data  (rt_val),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always_comb begin
        imm_val = {{(XLEN-16){imm16[15]}}, imm16};
        case (dec.ext_mode)
            EXT_ZERO: imm_val = {{(XLEN-16){1'b0}}, imm16};
            EXT_LUI:  imm_val = XLEN'({imm16, 16'h0000});
            default:  ;
        endcase
    end

    assign jump_tgt = {if_pc[XLEN-1:28], if_instr[25:0], 2'b00};
    assign rd_sel   = (opcode == OP_JAL)   ? LINK_REG :
                      (opcode == OP_RTYPE) ? if_instr[15:11] : rt;

    assign advance  = ex_ready || !ex_valid;
    assign load_use = ex_valid && ex_mem_read && (ex_rd != 5'd0) && if_valid &&
                      ((dec.uses_rs && rs == ex_rd) || (dec.uses_rt && rt == ex_rd));
    assign id_ready = flush || (advance && !load_use);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            ex_rs_data   <= '0;
            ex_rt_data   <= '0;
            ex_imm       <= '0;
            ex_jump_tgt  <= '0;
            ex_rd        <= '0;
            ex_func      <= '0;
            ex_alu_op    <= '0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_branch    <= 1'b0;
            ex_jump      <= 1'b0;
            ex_illegal   <= 1'b0;
        end else if (flush || (advance && load_use)) begin
            ex_valid     <= 1'b0;
            ex_alu_op    <= '0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_branch    <= 1'b0;
            ex_jump      <= 1'b0;
            ex_illegal   <= 1'b0;
        end else if (advance) begin
            // Controls are gated by if_valid so an empty slot never carries side effects.
            ex_valid     <= if_valid;
            ex_pc        <= if_pc;
            ex_rs_data   <= rs_val;
            ex_rt_data   <= rt_val;
            ex_imm       <= imm_val;
            ex_jump_tgt  <= jump_tgt;
            ex_rd        <= rd_sel;
            ex_func      <= if_instr[5:0];
            ex_alu_op    <= if_valid ? dec.alu_op : ALU_ADD;
            ex_reg_write <= if_valid && dec.reg_write;
            ex_mem_read  <= if_valid && dec.mem_read;
            ex_mem_write <= if_valid && dec.mem_write;
            ex_branch    <= if_valid && dec.branch;
            ex_jump      <= if_valid && dec.jump;
            ex_illegal   <= if_valid && dec.illegal;
        end
    end

endmodule
